// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: ALU operation codes, control bundle, forwarding selects.
package riscv_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int OPCODE_LENGTH = 4;
  localparam int REG_ADDR_W    = 5;

  localparam logic [OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_OR  = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_XOR = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SLL = 4'b0100;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SRL = 4'b0101;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = 4'b0110;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SRA = 4'b0111;
  localparam logic [OPCODE_LENGTH-1:0] ALU_BEQ = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_BGE = 4'b1001;
  localparam logic [OPCODE_LENGTH-1:0] ALU_BLT = 4'b1100;

  // 6-bit control bundle, MSB first: {reg_write, mem_read, mem_write, mem_to_reg, branch, jump}
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic jump;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EXM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding: picks EX/MEM result, MEM/WB data or the registered
// register-file value. EX/MEM is younger so it wins; x0 is never forwarded.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int RW = REG_ADDR_W
) (
  input  logic [RW-1:0] rs,
  input  logic [DW-1:0] reg_data,
  input  logic [RW-1:0] exm_rd,
  input  logic          exm_reg_write,
  input  logic [DW-1:0] exm_result,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_reg_write,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data
);

  fwd_sel_e sel_s;

  // Forwarding source select, EX/MEM ahead of MEM/WB
  always_comb begin
    sel_s = FWD_REG;
    if (exm_reg_write && (exm_rd != {RW{1'b0}}) && (exm_rd == rs)) begin
      sel_s = FWD_EXM;
    end else if (wb_reg_write && (wb_rd != {RW{1'b0}}) && (wb_rd == rs)) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_REG;
    end
  end

  // Data mux driven by the selected source
  always_comb begin
    data = reg_data;
    case (sel_s)
      FWD_EXM: data = exm_result;
      FWD_WB:  data = wb_data;
      FWD_REG: data = reg_data;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand selection, forwarding and load-use detection.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = riscv_pkg::DATA_WIDTH,
  parameter int OPCODE_LENGTH = riscv_pkg::OPCODE_LENGTH,
  parameter int REG_ADDR_W    = riscv_pkg::REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src_a,
  input  logic                     id_alu_src_b,
  input  logic [5:0]               id_ctrl,
  input  logic [REG_ADDR_W-1:0]    exm_rd,
  input  logic                     exm_reg_write,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic [5:0]               ex_ctrl,
  output logic                     load_use_hazard
);

  logic                     valid_r;
  logic [DATA_WIDTH-1:0]    pc_r;
  logic [DATA_WIDTH-1:0]    rs1_data_r;
  logic [DATA_WIDTH-1:0]    rs2_data_r;
  logic [DATA_WIDTH-1:0]    imm_r;
  logic [REG_ADDR_W-1:0]    rs1_r;
  logic [REG_ADDR_W-1:0]    rs2_r;
  logic [REG_ADDR_W-1:0]    rd_r;
  logic [OPCODE_LENGTH-1:0] op_r;
  logic                     src_a_r;
  logic                     src_b_r;
  ctrl_t                    ctrl_r;
  logic                     bubble_s;
  logic [DATA_WIDTH-1:0]    fwd_a_s;
  logic [DATA_WIDTH-1:0]    fwd_b_s;

  // Load-use detection and bubble decision (flush, hazard or empty ID slot)
  always_comb begin
    load_use_hazard = id_valid && valid_r && ctrl_r.mem_read &&
                      (rd_r != {REG_ADDR_W{1'b0}}) &&
                      ((rd_r == id_rs1) || (rd_r == id_rs2));
    bubble_s = 1'b0;
    if (flush) begin
      bubble_s = 1'b1;
    end else if (stall) begin
      bubble_s = 1'b0;
    end else if (load_use_hazard || !id_valid) begin
      bubble_s = 1'b1;
    end else begin
      bubble_s = 1'b0;
    end
  end

  // Stage register: reset/bubble clears everything, stall holds, otherwise capture ID
  always_ff @(posedge clk) begin
    if (!rst_n || bubble_s) begin
      valid_r    <= 1'b0;
      pc_r       <= {DATA_WIDTH{1'b0}};
      rs1_data_r <= {DATA_WIDTH{1'b0}};
      rs2_data_r <= {DATA_WIDTH{1'b0}};
      imm_r      <= {DATA_WIDTH{1'b0}};
      rs1_r      <= {REG_ADDR_W{1'b0}};
      rs2_r      <= {REG_ADDR_W{1'b0}};
      rd_r       <= {REG_ADDR_W{1'b0}};
      op_r       <= {OPCODE_LENGTH{1'b0}};
      src_a_r    <= 1'b0;
      src_b_r    <= 1'b0;
      ctrl_r     <= ctrl_t'(6'b000000);
    end else if (!stall) begin
      valid_r    <= 1'b1;
      pc_r       <= id_pc;
      rs1_data_r <= id_rs1_data;
      rs2_data_r <= id_rs2_data;
      imm_r      <= id_imm;
      rs1_r      <= id_rs1;
      rs2_r      <= id_rs2;
      rd_r       <= id_rd;
      op_r       <= id_alu_op;
      src_a_r    <= id_alu_src_a;
      src_b_r    <= id_alu_src_b;
      ctrl_r     <= ctrl_t'(id_ctrl);
    end
  end

  fwd_mux #(.DW(DATA_WIDTH), .RW(REG_ADDR_W)) u_fwd_a (
    .rs(rs1_r), .reg_data(rs1_data_r),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .data(fwd_a_s)
  );

  fwd_mux #(.DW(DATA_WIDTH), .RW(REG_ADDR_W)) u_fwd_b (
    .rs(rs2_r), .reg_data(rs2_data_r),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .data(fwd_b_s)
  );

  // ALU operand selection; store data always takes the forwarded rs2
  always_comb begin
    SrcA          = src_a_r ? pc_r : fwd_a_s;
    SrcB          = src_b_r ? imm_r : fwd_b_s;
    ex_store_data = fwd_b_s;
    Operation     = op_r;
    ex_valid      = valid_r;
    ex_pc         = pc_r;
    ex_imm        = imm_r;
    ex_rd         = rd_r;
    ex_ctrl       = ctrl_r;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural model plus directed literal checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_a, id_alu_src_b;
  logic [5:0]  id_ctrl;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_reg_write, wb_reg_write;
  logic [31:0] exm_result, wb_data;
  logic [31:0] SrcA, SrcB, ex_pc, ex_imm, ex_store_data;
  logic [3:0]  Operation;
  logic        ex_valid, load_use_hazard;
  logic [4:0]  ex_rd;
  logic [5:0]  ex_ctrl;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model of the instruction sitting in EX (all zero means bubble)
  typedef struct {
    bit          valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    bit          sa, sb;
    logic [5:0]  ctrl;
  } slot_t;
  slot_t m, empty_slot;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b), .id_ctrl(id_ctrl),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .load_use_hazard(load_use_hazard)
  );

  always #10 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a source operand reads in EX given the current bypass network
  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] regval);
    if (rs != 5'd0 && exm_reg_write && exm_rd == rs) return exm_result;
    if (rs != 5'd0 && wb_reg_write && wb_rd == rs) return wb_data;
    return regval;
  endfunction

  function automatic bit hazard_now();
    return id_valid && m.valid && m.ctrl[4] && m.rd != 5'd0 && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  // Model advance at each edge: reset > flush > stall > hazard > capture
  always @(posedge clk) begin
    if (!rst_n || flush) m <= empty_slot;
    else if (stall) m <= m;
    else if (hazard_now() || !id_valid) m <= empty_slot;
    else m <= '{1'b1, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
                id_alu_op, id_alu_src_a, id_alu_src_b, id_ctrl};
  end

  // Compare process: every cycle, mid low phase
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      cmp("SrcA", SrcA, m.sa ? m.pc : operand(m.rs1, m.a));
      cmp("SrcB", SrcB, m.sb ? m.imm : operand(m.rs2, m.b));
      cmp("store_data", ex_store_data, operand(m.rs2, m.b));
      cmp("Operation", {28'd0, Operation}, {28'd0, m.op});
      cmp("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
      cmp("ex_pc", ex_pc, m.pc);
      cmp("ex_imm", ex_imm, m.imm);
      cmp("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      cmp("ex_ctrl", {26'd0, ex_ctrl}, {26'd0, m.ctrl});
      cmp("hazard", {31'd0, load_use_hazard}, {31'd0, hazard_now()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #3;
  endtask

  task automatic id_set(input bit v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [5:0] c);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_ctrl = c;
    id_alu_op = 4'b0010; id_alu_src_a = 1'b0; id_alu_src_b = 1'b0;
    id_pc = 32'h0000_0040; id_imm = 32'h0000_0010;
  endtask

  task automatic rand_id();
    id_valid = ($urandom_range(0, 9) < 8);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7)); id_alu_op = 4'($urandom);
    id_alu_src_a = 1'($urandom); id_alu_src_b = 1'($urandom); id_ctrl = 6'($urandom);
  endtask

  initial begin
    empty_slot = '{1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 6'd0};
    m = empty_slot;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    exm_rd = 5'd0; exm_reg_write = 1'b0; exm_result = 32'd0;
    wb_rd = 5'd0; wb_reg_write = 1'b0; wb_data = 32'd0;
    rand_id();
    id_valid = 1'b1;
    @(negedge clk);
    // 1: reset with garbage on ID
    cyc(); cyc();
    chk_en = 1'b1;
    cmp("rst_valid", {31'd0, ex_valid}, 32'd0);
    cmp("rst_ctrl", {26'd0, ex_ctrl}, 32'd0);
    cmp("rst_SrcA", SrcA, 32'd0);
    cmp("rst_SrcB", SrcB, 32'd0);
    cmp("rst_op", {28'd0, Operation}, 32'd0);
    rst_n = 1'b1;
    // 2: capture ADD
    id_set(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b100000);
    cyc();
    cmp("add_SrcA", SrcA, 32'd5);
    cmp("add_SrcB", SrcB, 32'd7);
    cmp("add_op", {28'd0, Operation}, 32'd2);
    cmp("add_valid", {31'd0, ex_valid}, 32'd1);
    // 3: forwarding priority on rs1 = x3
    id_set(1'b1, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 6'b100000);
    cyc();
    stall = 1'b1; id_valid = 1'b0;
    exm_rd = 5'd3; exm_result = 32'hAA; exm_reg_write = 1'b1;
    wb_rd = 5'd3; wb_data = 32'hBB; wb_reg_write = 1'b1;
    #1 cmp("fwd_exm", SrcA, 32'hAA);
    exm_reg_write = 1'b0;
    #1 cmp("fwd_wb", SrcA, 32'hBB);
    exm_rd = 5'd0; wb_rd = 5'd0; exm_reg_write = 1'b1;
    #1 cmp("fwd_x0", SrcA, 32'h11);
    stall = 1'b0; exm_reg_write = 1'b0; wb_reg_write = 1'b0;
    // 4: load-use, lw x5 then add x6,x5,x1
    id_set(1'b1, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 6'b110100);
    cyc();
    id_set(1'b1, 5'd5, 5'd1, 5'd6, 32'h21, 32'h31, 6'b100000);
    #1 cmp("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
    cyc();
    cmp("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    cmp("lu_bubble_ctrl", {26'd0, ex_ctrl}, 32'd0);
    cmp("lu_hazard_clr", {31'd0, load_use_hazard}, 32'd0);
    cyc();
    cmp("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    cmp("lu_cap_rd", {27'd0, ex_rd}, 32'd6);
    // 5: stall holds, stall+flush bubbles
    stall = 1'b1;
    id_set(1'b1, 5'd7, 5'd7, 5'd9, 32'h99, 32'h98, 6'b100000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmp("stall_SrcA", SrcA, 32'h21);
      cmp("stall_SrcB", SrcB, 32'h31);
      cmp("stall_rd", {27'd0, ex_rd}, 32'd6);
    end
    flush = 1'b1;
    cyc();
    cmp("flush_valid", {31'd0, ex_valid}, 32'd0);
    cmp("flush_ctrl", {26'd0, ex_ctrl}, 32'd0);
    stall = 1'b0; flush = 1'b0;
    // 6: immediate / PC operands and store data
    id_set(1'b1, 5'd1, 5'd7, 5'd8, 32'h0, 32'h1234, 6'b001000);
    id_alu_src_a = 1'b1; id_alu_src_b = 1'b1; id_pc = 32'h100; id_imm = 32'hFFFF_FFFC;
    cyc();
    id_valid = 1'b0;
    exm_rd = 5'd7; exm_result = 32'h55; exm_reg_write = 1'b1;
    #1;
    cmp("imm_SrcB", SrcB, 32'hFFFF_FFFC);
    cmp("pc_SrcA", SrcA, 32'h100);
    cmp("store_fwd", ex_store_data, 32'h55);
    exm_reg_write = 1'b0;
    #1 cmp("store_reg", ex_store_data, 32'h1234);
    // Randomized phase, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      rand_id();
      rst_n = ($urandom_range(0, 49) != 0);
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      exm_rd = 5'($urandom_range(0, 7)); exm_reg_write = 1'($urandom); exm_result = $urandom;
      wb_rd = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom); wb_data = $urandom;
      cyc();
    end
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
